// File: rtl/comparator_bist.sv
// -----------------------------------------------------------------------------
// comparator_bist
//
// Built-in self-test sequencer for a WIDTH-bit combinational magnitude
// comparator. It sweeps every operand pair {A,B} (B inner loop, A outer loop)
// and holds each pair for SETTLE+1 cycles. On the last cycle of each pair it
// checks the comparator's three result flags against the unsigned compare of
// A and B. It reports pass/fail, a mismatch count and the first failing vector.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start               begin a sweep (accepted only when idle)
//   abort               stop a running sweep; partial error info is kept
//   A, B                operands driven to the comparator under test
//   A_equal_B,
//   A_greater_B,
//   B_greater_A         result flags returned by the comparator
//   busy                sweep in progress
//   done                one-cycle pulse when a sweep completes
//   pass                completed sweep had no mismatches (held until restart)
//   err_count           mismatching pairs in the current or last sweep
//   fail_valid          a mismatch has been captured
//   fail_a, fail_b      operands of the first mismatching pair
//   fail_flags          flags {eq, gt, lt} observed at the first mismatch
// -----------------------------------------------------------------------------
module comparator_bist #(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   input  logic               A_equal_B,
   input  logic               A_greater_B,
   input  logic               B_greater_A,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic [2:0]         fail_flags
);

   localparam int EW = 2*WIDTH + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] settle_cnt;
   logic       sample_now;
   logic       last_pair;
   logic       mismatch;
   logic [2:0] observed;
   logic [2:0] expected;

   // Sample point is the last cycle of the current pair; the pair after
   // (max,max) does not exist, so that sample also ends the sweep.
   always_comb begin
      sample_now = (state == WAIT) && (settle_cnt == 4'(SETTLE));
      last_pair  = (A == '1) && (B == '1);
      observed   = {A_equal_B, A_greater_B, B_greater_A};
      expected   = {(A == B), (A > B), (A < B)};
      mismatch   = (observed != expected);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; abort wins over a sample on the same edge, and DONE
   // always falls back to IDLE regardless of start.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (sample_now && last_pair) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         WAIT:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Operand walk, settle counter and result capture. The next pair is
   // loaded on the same edge the current pair is sampled. The final pair is
   // left on A/B after the sweep ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A          <= '0;
         B          <= '0;
         settle_cnt <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_flags <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  A          <= '0;
                  B          <= '0;
                  settle_cnt <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (abort) begin
                  A          <= '0;
                  B          <= '0;
                  settle_cnt <= '0;
                  pass       <= 1'b0;
               end else if (sample_now) begin
                  settle_cnt <= '0;
                  if (mismatch) begin
                     err_count <= err_count + EW'(1);
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= A;
                        fail_b     <= B;
                        fail_flags <= observed;
                     end
                  end
                  if (last_pair) begin
                     pass <= (err_count == '0) && !mismatch;
                  end else if (B == '1) begin
                     B <= '0;
                     A <= A + WIDTH'(1);
                  end else begin
                     B <= B + WIDTH'(1);
                  end
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_bist.sv
// -----------------------------------------------------------------------------
// tb_comparator_bist
//
// Self-checking bench for comparator_bist. A behavioural comparator with a
// programmable per-pair fault table feeds the main instance (WIDTH=2,
// SETTLE=2). A reference model tracks cycles since the start edge and derives
// every output from the sweep arithmetic. A second instance (WIDTH=1,
// SETTLE=0) with a fault-free comparator covers the minimum configuration.
// -----------------------------------------------------------------------------
module tb_comparator_bist;

   localparam int W   = 2;
   localparam int S   = 2;
   localparam int NP  = 1 << (2*W);
   localparam int TOT = NP * (S + 1);

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           abort;
   logic [W-1:0]   a_op;
   logic [W-1:0]   b_op;
   logic           eq_f;
   logic           gt_f;
   logic           lt_f;
   logic           busy;
   logic           done;
   logic           pass;
   logic [2*W:0]   err_count;
   logic           fail_valid;
   logic [W-1:0]   fail_a;
   logic [W-1:0]   fail_b;
   logic [2:0]     fail_flags;

   logic           start1;
   logic           abort1;
   logic [0:0]     a1;
   logic [0:0]     b1;
   logic           eq1;
   logic           gt1;
   logic           lt1;
   logic           busy1;
   logic           done1;
   logic           pass1;
   logic [2:0]     err_count1;
   logic           fail_valid1;
   logic [0:0]     fail_a1;
   logic [0:0]     fail_b1;
   logic [2:0]     fail_flags1;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   logic [2:0] fault_mask [NP];
   logic [2:0] sweep_mask [NP];
   logic [2:0] true_flags;

   bit m_run;
   bit m_done;
   bit m_pass;
   bit m_hold;
   int m_k;

   int cmp_idx;
   int cmp_first;

   comparator_bist #(.WIDTH(W), .SETTLE(S)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .A           (a_op),
      .B           (b_op),
      .A_equal_B   (eq_f),
      .A_greater_B (gt_f),
      .B_greater_A (lt_f),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count),
      .fail_valid  (fail_valid),
      .fail_a      (fail_a),
      .fail_b      (fail_b),
      .fail_flags  (fail_flags)
   );

   comparator_bist #(.WIDTH(1), .SETTLE(0)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start1),
      .abort       (abort1),
      .A           (a1),
      .B           (b1),
      .A_equal_B   (eq1),
      .A_greater_B (gt1),
      .B_greater_A (lt1),
      .busy        (busy1),
      .done        (done1),
      .pass        (pass1),
      .err_count   (err_count1),
      .fail_valid  (fail_valid1),
      .fail_a      (fail_a1),
      .fail_b      (fail_b1),
      .fail_flags  (fail_flags1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Comparator under test: correct unsigned compare with a per-pair XOR fault.
   always_comb begin
      true_flags = {(a_op == b_op), (a_op > b_op), (a_op < b_op)};
      {eq_f, gt_f, lt_f} = true_flags ^ fault_mask[{a_op, b_op}];
   end

   assign {eq1, gt1, lt1} = {(a1 == b1), (a1 > b1), (a1 < b1)};

   // Reference model: m_k counts cycles since the accepted start edge.
   // sweep_mask snapshots the fault table so results stay frozen afterwards.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  <= 1'b0;
         m_done <= 1'b0;
         m_pass <= 1'b0;
         m_hold <= 1'b0;
         m_k    <= 0;
         for (int i = 0; i < NP; i++) sweep_mask[i] <= 3'b000;
      end else if (m_run) begin
         if (abort) begin
            m_run  <= 1'b0;
            m_hold <= 1'b0;
         end else if (m_k + 1 == TOT) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
            m_hold <= 1'b1;
            m_k    <= m_k + 1;
            m_pass <= (faultyBelow(NP) == 0);
         end else begin
            m_k <= m_k + 1;
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (start) begin
         m_run  <= 1'b1;
         m_k    <= 0;
         m_pass <= 1'b0;
         m_hold <= 1'b0;
         for (int i = 0; i < NP; i++) sweep_mask[i] <= fault_mask[i];
      end
   end

   function automatic int faultyBelow(input int n);
      int cnt = 0;
      for (int i = 0; i < n; i++) if (sweep_mask[i] != 3'b000) cnt++;
      return cnt;
   endfunction

   function automatic int sampledPairs();
      int s = m_k / (S + 1);
      return (s > NP) ? NP : s;
   endfunction

   function automatic int firstFaulty(input int n);
      for (int i = 0; i < n; i++) if (sweep_mask[i] != 3'b000) return i;
      return -1;
   endfunction

   function automatic logic [2:0] trueFlagsOf(input int idx);
      int a = idx >> W;
      int b = idx & ((1 << W) - 1);
      return {(a == b), (a > b), (a < b)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every main-instance output against the model.
   always @(negedge clk) begin
      if (check_en) begin
         if (m_run || m_hold) begin
            cmp_idx = (sampledPairs() >= NP) ? NP - 1 : sampledPairs();
         end else begin
            cmp_idx = 0;
         end
         cmp_first = firstFaulty(sampledPairs());
         checkOutput("busy", busy, m_run);
         checkOutput("done", done, m_done);
         checkOutput("pass", pass, m_pass);
         checkOutput("A", a_op, cmp_idx >> W);
         checkOutput("B", b_op, cmp_idx & ((1 << W) - 1));
         checkOutput("err_count", err_count, faultyBelow(sampledPairs()));
         checkOutput("fail_valid", fail_valid, cmp_first >= 0);
         if (cmp_first >= 0) begin
            checkOutput("fail_a", fail_a, cmp_first >> W);
            checkOutput("fail_b", fail_b, cmp_first & ((1 << W) - 1));
            checkOutput("fail_flags", fail_flags,
                        trueFlagsOf(cmp_first) ^ sweep_mask[cmp_first]);
         end
      end
   end

   task automatic applyStimulus(input bit s, input bit a);
      @(negedge clk);
      start = s;
      abort = a;
   endtask

   // mode 0: correct, 1: eq stuck at 0, 2: gt/lt swapped, 3: random faults
   task automatic setMask(input int mode);
      for (int i = 0; i < NP; i++) begin
         int a;
         int b;
         a = i >> W;
         b = i & ((1 << W) - 1);
         case (mode)
            1:       fault_mask[i] = (a == b) ? 3'b100 : 3'b000;
            2:       fault_mask[i] = (a != b) ? 3'b011 : 3'b000;
            3:       fault_mask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            default: fault_mask[i] = 3'b000;
         endcase
      end
   endtask

   // k counts negedges after the start edge; start re-pulsed at k==r1/r2.
   task automatic waitDone(input int r1, input int r2, output int lat);
      lat = -1;
      for (int k = 0; k < 4*TOT; k++) begin
         applyStimulus((k == r1) || (k == r2), 1'b0);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) checkOutput("done_timeout", 0, 1);
   endtask

   task automatic runSweep(input int r1, input int r2, output int lat);
      applyStimulus(1'b1, 1'b0);
      waitDone(r1, r2, lat);
   endtask

   initial begin
      int lat;
      int seen;
      start  = 1'b0;
      abort  = 1'b0;
      start1 = 1'b0;
      abort1 = 1'b0;
      rst_n  = 1'b0;
      setMask(0);
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err_count, 0);
      checkOutput("rst_pass", pass, 0);
      checkOutput("rst_fail_valid", fail_valid, 0);
      rst_n    = 1'b1;
      check_en = 1'b1;

      $display("[TB] correct comparator sweep");
      setMask(0);
      runSweep(-1, -1, lat);
      checkOutput("t1_latency", lat, 48);
      checkOutput("t1_pass", pass, 1);
      checkOutput("t1_err", err_count, 0);
      checkOutput("t1_fail_valid", fail_valid, 0);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] A_equal_B stuck at 0");
      setMask(1);
      runSweep(-1, -1, lat);
      checkOutput("t2_pass", pass, 0);
      checkOutput("t2_err", err_count, 4);
      checkOutput("t2_fail_a", fail_a, 0);
      checkOutput("t2_fail_b", fail_b, 0);
      checkOutput("t2_fail_flags", fail_flags, 3'b000);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] gt/lt swapped");
      setMask(2);
      runSweep(-1, -1, lat);
      checkOutput("t3_err", err_count, 12);
      checkOutput("t3_fail_a", fail_a, 0);
      checkOutput("t3_fail_b", fail_b, 1);
      checkOutput("t3_fail_flags", fail_flags, 3'b010);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] start while busy and in DONE");
      setMask(1);
      runSweep(10, 20, lat);
      checkOutput("t4_latency", lat, 48);
      start = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("t4_done_start_ignored", busy, 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t4_restart_busy", busy, 1);
      checkOutput("t4_restart_err", err_count, 0);
      checkOutput("t4_restart_pass", pass, 0);
      waitDone(-1, -1, lat);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] reset mid-sweep");
      setMask(1);
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k <= 16; k++) applyStimulus(1'b0, 1'b0);
      checkOutput("t5_pre_reset_A", a_op, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_busy", busy, 0);
      checkOutput("t5_rst_A", a_op, 0);
      checkOutput("t5_rst_B", b_op, 0);
      checkOutput("t5_rst_err", err_count, 0);
      checkOutput("t5_rst_fail_valid", fail_valid, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] abort during pair (2,0)");
      setMask(1);
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k <= 25; k++) applyStimulus(1'b0, k == 25);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t5_abort_busy", busy, 0);
      checkOutput("t5_abort_err", err_count, 2);
      checkOutput("t5_abort_A", a_op, 0);
      checkOutput("t5_abort_fail_valid", fail_valid, 1);
      seen = 0;
      for (int k = 0; k < TOT + 10; k++) begin
         applyStimulus(1'b0, 1'b0);
         if (done === 1'b1) seen++;
      end
      checkOutput("t5_no_done", seen, 0);

      $display("[TB] randomized fault tables");
      for (int r = 0; r < 6; r++) begin
         setMask(3);
         if (r % 3 == 2) begin
            int ab_at;
            ab_at = int'($urandom_range(2, TOT - 4));
            applyStimulus(1'b1, 1'b0);
            for (int k = 0; k <= ab_at; k++) applyStimulus(1'b0, k == ab_at);
         end else begin
            runSweep(-1, -1, lat);
            checkOutput("rand_latency", lat, TOT);
         end
         applyStimulus(1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0);
      end

      $display("[TB] WIDTH=1 SETTLE=0 instance");
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (k < 4) begin
            checkOutput("t6_A", a1, k >> 1);
            checkOutput("t6_B", b1, k & 1);
            checkOutput("t6_busy", busy1, 1);
         end
         if (done1 === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      checkOutput("t6_latency", lat, 4);
      checkOutput("t6_pass", pass1, 1);
      checkOutput("t6_err", err_count1, 0);
      checkOutput("t6_fail_valid", fail_valid1, 0);
      @(negedge clk);
      checkOutput("t6_idle_busy", busy1, 0);

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
